// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
//   - ifu_state_e : fetch FSM state encoding (2 bits)
//   - ifu_buf_t   : single-entry output buffer {valid, inst, addr}
//   - word_align  : clears the byte-offset bits of an address
package ifu_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] IFU_INST_NOP = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] IFU_PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10
  } ifu_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] addr;
  } ifu_buf_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifu.sv
// ifu: instruction fetch unit, producer side of the if_id interface.
// Owns the PC, fetches one 32-bit word at a time over a req/gnt/rvalid
// handshake (at most one outstanding) and presents {inst, addr} through a
// registered single-entry buffer with a valid/ready handshake.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous reset, active-low
//   jump_en_i      redirect pulse from ex
//   jump_addr_i    redirect target (low two bits ignored)
//   hold_flag_i    stall: blocks the start of a new fetch
//   imem_req_o     fetch request
//   imem_addr_o    fetch address (current PC)
//   imem_gnt_i     memory accepted the request
//   imem_rvalid_i  read data valid
//   imem_rdata_i   fetched word
//   inst_o         instruction to if_id
//   inst_addr_o    address of inst_o
//   inst_valid_o   inst_o/inst_addr_o valid
//   inst_ready_i   if_id accepts this cycle
//
// state  | meaning
// S_IDLE | no request; waits for a free buffer and no hold
// S_REQ  | request on the bus at pc_q until granted
// S_WAIT | granted, waiting for the response (dropped if drop_q)
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter logic [31:0] NOP_INST = IFU_INST_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic        drop_q, drop_d;
  logic        req_q, req_d;
  ifu_buf_t    buf_q, buf_d;

  logic buf_free;
  logic fire_gnt;
  logic fire_rsp;

  // A fetch may only start when the buffer is empty or is being drained
  // this cycle, so a response never lands on top of an unread entry.
  assign buf_free = !buf_q.valid || inst_ready_i;
  assign fire_gnt = (state_q == S_REQ)  && imem_gnt_i;
  assign fire_rsp = (state_q == S_WAIT) && imem_rvalid_i;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    drop_d       = drop_q;

    case (state_q)
      S_IDLE: begin
        if (!hold_flag_i && buf_free) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // hold does not withdraw a request already on the bus
        if (imem_gnt_i) begin
          fetch_addr_d = pc_q;
          pc_d         = pc_q + IFU_PC_STEP;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          drop_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Redirect wins over everything. A request granted this cycle, or one
    // still waiting for data, belongs to the old path and must be dropped.
    if (jump_en_i) begin
      pc_d = word_align(jump_addr_i);
      if (state_q == S_IDLE) begin
        state_d = S_IDLE;
      end
      if (fire_gnt || ((state_q == S_WAIT) && !imem_rvalid_i)) begin
        drop_d = 1'b1;
      end
    end
  end

  always_comb begin
    buf_d = buf_q;
    if (buf_q.valid && inst_ready_i) begin
      buf_d.valid = 1'b0;
      buf_d.inst  = NOP_INST;
    end
    if (fire_rsp && !drop_q) begin
      buf_d.valid = 1'b1;
      buf_d.inst  = imem_rdata_i;
      buf_d.addr  = fetch_addr_q;
    end
    if (jump_en_i) begin
      buf_d.valid = 1'b0;
      buf_d.inst  = NOP_INST;
    end
  end

  assign req_d = (state_d == S_REQ);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      fetch_addr_q <= RESET_PC;
      drop_q       <= 1'b0;
      req_q        <= 1'b0;
      buf_q.valid  <= 1'b0;
      buf_q.inst   <= NOP_INST;
      buf_q.addr   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      drop_q       <= drop_d;
      req_q        <= req_d;
      buf_q        <= buf_d;
    end
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = pc_q;
  assign inst_o       = buf_q.inst;
  assign inst_addr_o  = buf_q.addr;
  assign inst_valid_o = buf_q.valid;

endmodule

// File: tb/tb_ifu.sv
module tb_ifu;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_flag_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
  logic        inst_ready_i;

  always #5 clk = ~clk;

  ifu dut (
    .clk          (clk),
    .rst          (rst),
    .jump_en_i    (jump_en_i),
    .jump_addr_i  (jump_addr_i),
    .hold_flag_i  (hold_flag_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i)
  );

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  chk_t        chk_q[$];
  logic [63:0] exp_q[$];
  int          hs_cyc_q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  logic        gnt_en = 1'b0;
  int          lat    = 1;
  int          pend   = 0;
  logic [31:0] pend_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return 32'h1000_0000 | a;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // memory: grants when enabled, answers 'lat' cycles after the grant
  initial begin
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      imem_rvalid_i = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = mem_word(pend_addr);
        end
      end
      imem_gnt_i = imem_req_o && gnt_en && (pend == 0);
      if (imem_gnt_i) begin
        pend      = lat;
        pend_addr = imem_addr_o;
      end
    end
  end

  // checker: owns the counters; drains posted checks and scores handshakes
  initial begin
    chk_t        c;
    logic [63:0] e;
    forever begin
      @(negedge clk);
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        total++;
        if (c.act !== c.exp) begin
          bad++;
          $display("FAIL %s: got %h want %h", c.name, c.act, c.exp);
        end
      end
      if (rst && inst_valid_o && inst_ready_i) begin
        hs_cyc_q.push_back(cyc);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_extra: got inst=%h addr=%h want none", inst_o, inst_addr_o);
        end else begin
          e = exp_q.pop_front();
          if ({inst_o, inst_addr_o} !== e) begin
            bad++;
            $display("FAIL sb_data: got inst=%h addr=%h want inst=%h addr=%h",
                     inst_o, inst_addr_o, e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  task automatic post(input string n, input logic [31:0] a, input logic [31:0] e);
    chk_t c;
    c.name = n;
    c.act  = a;
    c.exp  = e;
    chk_q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic wait_req(input string n);
    int k = 0;
    while (!imem_req_o && k < 50) begin tick(); k++; end
    if (!imem_req_o) post({"timeout_", n}, {31'b0, imem_req_o}, 32'd1);
  endtask

  task automatic wait_req_addr(input string n, input logic [31:0] a);
    int k = 0;
    while (!(imem_req_o && imem_addr_o == a) && k < 50) begin tick(); k++; end
    if (!(imem_req_o && imem_addr_o == a)) post({"timeout_", n}, imem_addr_o, a);
  endtask

  task automatic wait_valid_addr(input string n, input logic [31:0] a);
    int k = 0;
    while (!(inst_valid_o && inst_addr_o == a) && k < 50) begin tick(); k++; end
    if (!(inst_valid_o && inst_addr_o == a)) post({"timeout_", n}, inst_addr_o, a);
  endtask

  task automatic wait_hs(input string n, input int cnt);
    int k = 0;
    while (hs_cyc_q.size() < cnt && k < 100) begin tick(); k++; end
    if (hs_cyc_q.size() < cnt) post({"timeout_", n}, 32'(hs_cyc_q.size()), 32'(cnt));
  endtask

  task automatic check_reset_outputs(input string n);
    post({n, "_req"},   {31'b0, imem_req_o},   32'd0);
    post({n, "_addr"},  imem_addr_o,           32'h0);
    post({n, "_valid"}, {31'b0, inst_valid_o}, 32'd0);
    post({n, "_inst"},  inst_o,                32'h0000_0013);
    post({n, "_iaddr"}, inst_addr_o,           32'h0);
  endtask

  initial begin
    int base;
    rst          = 1'b1;
    jump_en_i    = 1'b0;
    jump_addr_i  = '0;
    hold_flag_i  = 1'b0;
    inst_ready_i = 1'b1;
    #1 rst = 1'b0;
    #1 check_reset_outputs("rst0");

    // first fetch and sequential stream 0,4,8,C
    exp_q.push_back({32'h0050_0093, 32'h0000_0000});
    exp_q.push_back({32'h1000_0004, 32'h0000_0004});
    exp_q.push_back({32'h1000_0008, 32'h0000_0008});
    exp_q.push_back({32'h1000_000C, 32'h0000_000C});
    gnt_en = 1'b1;
    lat    = 1;
    repeat (2) tick();
    rst = 1'b1;
    wait_req("r0");
    post("req_addr0", imem_addr_o, 32'h0);
    wait_hs("hs0", 1);
    wait_req("r1");
    post("req_addr1", imem_addr_o, 32'h4);
    wait_hs("hs3", 4);
    post("gap01", 32'(hs_cyc_q[1] - hs_cyc_q[0]), 32'd3);
    post("gap12", 32'(hs_cyc_q[2] - hs_cyc_q[1]), 32'd3);
    post("gap23", 32'(hs_cyc_q[3] - hs_cyc_q[2]), 32'd3);

    // backpressure: word at 0x10 held 5 cycles
    inst_ready_i = 1'b0;
    exp_q.push_back({32'h1000_0010, 32'h0000_0010});
    wait_valid_addr("v10", 32'h10);
    for (int i = 0; i < 5; i++) begin
      tick();
      post("stall_valid", {31'b0, inst_valid_o}, 32'd1);
      post("stall_inst",  inst_o,                32'h1000_0010);
      post("stall_addr",  inst_addr_o,           32'h10);
      post("stall_req",   {31'b0, imem_req_o},   32'd0);
    end
    inst_ready_i = 1'b1;
    tick();
    post("resume_req",  {31'b0, imem_req_o}, 32'd1);
    post("resume_addr", imem_addr_o,         32'h14);
    gnt_en = 1'b0;
    tick();

    // jump in the same cycle as the grant for 0x8
    do_reset();
    base   = hs_cyc_q.size();
    gnt_en = 1'b1;
    exp_q.push_back({32'h0050_0093, 32'h0000_0000});
    exp_q.push_back({32'h1000_0004, 32'h0000_0004});
    exp_q.push_back({32'h1000_0100, 32'h0000_0100});
    wait_req_addr("r8", 32'h8);
    jump_en_i   = 1'b1;
    jump_addr_i = 32'h100;
    tick();
    jump_en_i = 1'b0;
    post("jg_pc",  imem_addr_o,         32'h100);
    post("jg_req", {31'b0, imem_req_o}, 32'd0);
    wait_req("r100");
    post("jg_req_addr", imem_addr_o, 32'h100);
    tick();
    gnt_en = 1'b0;
    wait_hs("hs100", base + 3);

    // jump while a word is held with ready low; unaligned target
    do_reset();
    base   = hs_cyc_q.size();
    gnt_en = 1'b1;
    exp_q.push_back({32'h0050_0093, 32'h0000_0000});
    wait_hs("hs_j0", base + 1);
    inst_ready_i = 1'b0;
    wait_valid_addr("v4", 32'h4);
    exp_q.push_back({32'h1000_0200, 32'h0000_0200});
    jump_en_i   = 1'b1;
    jump_addr_i = 32'h203;
    tick();
    jump_en_i = 1'b0;
    post("jb_valid", {31'b0, inst_valid_o}, 32'd0);
    post("jb_inst",  inst_o,                32'h0000_0013);
    post("jb_pc",    imem_addr_o,           32'h200);
    inst_ready_i = 1'b1;
    wait_req("r200");
    post("jb_req_addr", imem_addr_o, 32'h200);
    tick();
    gnt_en = 1'b0;
    wait_hs("hs200", base + 2);

    // hold from idle, hold during a pending request
    hold_flag_i = 1'b1;
    do_reset();
    base = hs_cyc_q.size();
    for (int i = 0; i < 4; i++) begin
      tick();
      post("hold_idle_req", {31'b0, imem_req_o}, 32'd0);
    end
    hold_flag_i = 1'b0;
    tick();
    tick();
    post("hold_rel_req",  {31'b0, imem_req_o}, 32'd1);
    post("hold_rel_addr", imem_addr_o,         32'h0);
    hold_flag_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      post("hold_req_kept", {31'b0, imem_req_o}, 32'd1);
    end
    exp_q.push_back({32'h0050_0093, 32'h0000_0000});
    gnt_en = 1'b1;
    wait_hs("hs_hold", base + 1);
    gnt_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      post("hold_no_req", {31'b0, imem_req_o}, 32'd0);
    end

    // reset during S_WAIT; the late response must be ignored
    lat         = 4;
    gnt_en      = 1'b1;
    hold_flag_i = 1'b0;
    wait_req("r4");
    post("late_req_addr", imem_addr_o, 32'h4);
    tick();
    gnt_en = 1'b0;
    post("late_wait_req", {31'b0, imem_req_o}, 32'd0);
    rst = 1'b0;
    #1 check_reset_outputs("rst_mid");
    tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      post("late_valid", {31'b0, inst_valid_o}, 32'd0);
    end
    post("late_req", {31'b0, imem_req_o}, 32'd1);
    lat = 1;
    exp_q.push_back({32'h0050_0093, 32'h0000_0000});
    gnt_en = 1'b1;
    wait_hs("hs_late", base + 2);
    gnt_en = 1'b0;

    repeat (3) tick();
    post("sb_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
